fir_out_stage: RTL



---
 rtl/fir_out_stage_if.sv | 28 ++
 rtl/fir_out_stage.sv | 105 ++++++++++
 2 files changed

// File: rtl/fir_out_stage_if.sv
// Stream bundle for the FIR output stage: scaled-input strobe
// plus the buffered valid/ready output.
interface fir_out_stage_if #(
   parameter int IN_W  = 11,
   parameter int OUT_W = 8
);
   logic signed [IN_W-1:0]  in_data;
   logic                    in_valid;
   logic signed [OUT_W-1:0] out_data;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output in_data,
      output in_valid,
      input  out_data,
      input  out_valid,
      output out_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output out_data,
      output out_valid,
      input  out_ready
   );
endinterface

// File: rtl/fir_out_stage.sv
// FIR output stage: shift, saturate, buffer in a small FIFO.
// Define FIR_OUT_ROUND_EN for round-half-up scaling.
module fir_out_stage #(
   parameter int IN_W  = 11,
   parameter int OUT_W = 8,
   parameter int SHIFT = 2,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   fir_out_stage_if.slave           bus,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow,
   output logic [7:0]               sat_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic signed [IN_W:0] MAXV =
      (IN_W+1)'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [IN_W:0] MINV = ~MAXV;

   logic signed [OUT_W-1:0] mem [DEPTH];
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [LW-1:0]           level;

   logic signed [IN_W:0]    ext;
   logic signed [IN_W:0]    sum;
   logic signed [IN_W:0]    s;
   logic                    clip_hi;
   logic                    clip_lo;
   logic signed [OUT_W-1:0] scaled;

   logic full;
   logic push;
   logic pop;
   logic drop;

   // One extra bit keeps the rounding add from wrapping.
   assign ext = {bus.in_data[IN_W-1], bus.in_data};

`ifdef FIR_OUT_ROUND_EN
   localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [IN_W:0] RND =
      (SHIFT > 0) ? (IN_W+1)'(1 << RSH) : '0;
   assign sum = ext + RND;
`else
   assign sum = ext;
`endif

   assign s       = sum >>> SHIFT;
   assign clip_hi = s > MAXV;
   assign clip_lo = s < MINV;

   always_comb begin
      scaled = s[OUT_W-1:0];
      if (clip_hi)
         scaled = MAXV[OUT_W-1:0];
      else if (clip_lo)
         scaled = MINV[OUT_W-1:0];
   end

   assign full = level == LW'(DEPTH);
   assign pop  = bus.out_valid & bus.out_ready & ~clear;
   assign push = bus.in_valid & ~clear & (~full | pop);
   assign drop = bus.in_valid & ~clear & full & ~pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
         sat_cnt  <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
         sat_cnt  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= scaled;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            level <= level + LW'(1);
         else if (pop && !push)
            level <= level - LW'(1);
         if (drop)
            overflow <= 1'b1;
         if (push && (clip_hi || clip_lo) && sat_cnt != 8'hFF)
            sat_cnt <= sat_cnt + 8'd1;
      end
   end

   assign bus.out_data  = mem[rd_ptr];
   assign bus.out_valid = level != '0;
   assign fifo_level    = level;
endmodule
